graph_edge_fetcher: RTL and testbench
=====================================

# graph_edge_fetcher

Adjacency-list server feeding the path-accumulation top level. Holds the graph in two on-chip tables: a per-node table of base address and out-degree, and a flat edge array of successor indices. On request it looks up the node the FSM currently holds in `node_idx_reg` and streams that node's successors back as `next_node_idx` and `next_node_counter`. Tables are loaded once over a simple write port before a run.

## Interface
- PARAM_NODE_IDX_WIDTH, 10, node index width; node table depth is 2**this
- PARAM_COUNTER_WIDTH, 4, out-degree / remaining-edge counter width (max 15 edges per node)
- PARAM_EDGE_ADDR_WIDTH, 12, edge array address width; depth is 2**this
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_wr_en  in  1  table write strobe
- cfg_sel  in  1  0 = node table, 1 = edge array
- cfg_addr  in  max(NODE_IDX,EDGE_ADDR)  write address; upper bits ignored for the node table
- cfg_data  in  EDGE_ADDR+COUNTER  node table: {base, degree}; edge array: low NODE_IDX bits = successor
- cfg_drop  out  1  one-cycle pulse when a write is discarded
- req  in  1  start lookup of node_idx
- node_idx  in  NODE_IDX  node to expand; sampled only when req=1
- advance  in  1  consumer took the presented edge
- next_valid  out  1  next_node_idx / next_node_counter are valid
- next_node_idx  out  NODE_IDX  current successor
- next_node_counter  out  COUNTER  edges remaining including the presented one
- done  out  1  all edges of the requested node delivered; held until the next req

## Operation
- FSM states: IDLE, LOOKUP, FETCH, PRESENT, DONE.
- IDLE/DONE + req: node table is read at node_idx. Next state is LOOKUP. done is cleared.
- LOOKUP: latch base and degree into rem_cnt.
  - If degree==0: go to DONE.
  - Otherwise: read the edge array at base, set edge_ptr=base+1, go to FETCH.
- FETCH: register the edge data into next_node_idx, drive next_node_counter=rem_cnt, set next_valid=1, go to PRESENT.
- PRESENT, advance=1: next_valid→0, rem_cnt−1.
  - If the result is 0: go to DONE.
  - Otherwise: read the edge array at edge_ptr, edge_ptr+1, go to FETCH.
- PRESENT, advance=0: hold all outputs stable.
- advance is ignored when next_valid=0.
- req in any state other than IDLE/DONE aborts the current node and restarts LOOKUP for the new node_idx. next_valid drops the same cycle.
- req and advance in the same cycle: req wins.
- cfg writes:
  - Accepted only in IDLE or DONE.
  - In other states the write is dropped and cfg_drop pulses.
  - cfg_wr_en and req in the same cycle: the write commits first, and the lookup sees the new data.
- Arithmetic:
  - edge_ptr wraps modulo 2**EDGE_ADDR_WIDTH.
  - rem_cnt never underflows, because advance at 0 cannot occur.
  - The degree field is used as-is, with no saturation.

## Timing
- Both tables have a synchronous read with 1-cycle latency. Writes are synchronous.
- req sampled at edge N: next_valid=1 from edge N+3 (LOOKUP at N+1, FETCH at N+2).
- Degree-0 node: done=1 from edge N+2, and next_valid never rises.
- advance at edge M: next edge valid from edge M+2. Throughput is one edge per 2 cycles.
- Last advance at edge M: done=1 from edge M+1.
- Reset values:
  - next_valid=0, next_node_idx=0, next_node_counter=0, done=0, cfg_drop=0, state=IDLE.
  - Table contents are not reset.
- rst_n asserted mid-stream: outputs go to reset values immediately (asynchronous). Tables retain contents.

## Structure
- Shared package graph_pkg holds:
  - default widths
  - FSM state encoding (3-bit localparams)
  - the packed node-entry struct {base, degree}
  - cfg_sel encodings
- One sub-module, graph_sp_ram: parameterised width/depth, one write port, one registered read port. It is instantiated twice, once for the node table and once for the edge array.

## Test plan
- Load node 5 = {base 100, deg 3}, edges[100..102] = 7, 9, 11; req node 5, advance whenever valid.
  - Outputs (7,3), (9,2), (11,1).
  - First valid 3 cycles after req; consecutive valids 2 cycles apart.
  - done one cycle after the last advance.
- Node 6 = {base 0, deg 0}; req.
  - done at N+2.
  - next_valid never asserted.
- Node 1 = {base 4095, deg 2}, edges[4095] = 3, edges[0] = 4.
  - Outputs (3,2) then (4,1), showing edge-pointer wraparound.
- While presenting node 5's second edge, req node 1.
  - next_valid drops immediately.
  - Node 1's first edge follows 3 cycles later.
  - Node 5's remaining edge is never output.
- cfg write during PRESENT: cfg_drop pulses and the table is unchanged on re-read. Hold advance low 10 cycles: outputs stable. Assert rst_n low mid-stream: all outputs 0 and state IDLE, then a req after reset works with the tables intact.

Source files
------------

// File: rtl/graph_pkg.sv
// Shared widths, FSM encoding and table entry layout for the graph edge fetcher.
package graph_pkg;

    localparam int NODE_IDX_W  = 10;
    localparam int COUNTER_W   = 4;
    localparam int EDGE_ADDR_W = 12;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOOKUP  = 3'd1;
    localparam logic [2:0] ST_FETCH   = 3'd2;
    localparam logic [2:0] ST_PRESENT = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic CFG_SEL_NODE = 1'b0;
    localparam logic CFG_SEL_EDGE = 1'b1;

    typedef struct packed {
        logic [EDGE_ADDR_W-1:0] base;
        logic [COUNTER_W-1:0]   degree;
    } node_entry_t;

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/graph_sp_ram.sv
// Single-port-write / registered-read table; a read of the address being written returns the new data.
module graph_sp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Table write and registered read with write-first bypass
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_we && (i_waddr == i_raddr)) begin
            r_rdata <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/graph_edge_fetcher.sv
// Adjacency-list server: looks up a node's {base, degree} and streams its successors one per handshake.
module graph_edge_fetcher
    import graph_pkg::*;
#(
    parameter int PARAM_NODE_IDX_WIDTH  = NODE_IDX_W,
    parameter int PARAM_COUNTER_WIDTH   = COUNTER_W,
    parameter int PARAM_EDGE_ADDR_WIDTH = EDGE_ADDR_W,
    parameter int CFG_ADDR_W            = max_width(PARAM_NODE_IDX_WIDTH, PARAM_EDGE_ADDR_WIDTH)
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               cfg_wr_en,
    input  logic                                               cfg_sel,
    input  logic [CFG_ADDR_W-1:0]                              cfg_addr,
    input  logic [PARAM_EDGE_ADDR_WIDTH+PARAM_COUNTER_WIDTH-1:0] cfg_data,
    output logic                                               cfg_drop,
    input  logic                                               req,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0]                    node_idx,
    input  logic                                               advance,
    output logic                                               next_valid,
    output logic [PARAM_NODE_IDX_WIDTH-1:0]                    next_node_idx,
    output logic [PARAM_COUNTER_WIDTH-1:0]                     next_node_counter,
    output logic                                               done
);

    localparam int NI = PARAM_NODE_IDX_WIDTH;
    localparam int CW = PARAM_COUNTER_WIDTH;
    localparam int EA = PARAM_EDGE_ADDR_WIDTH;

    logic [2:0]       r_state;
    logic [EA-1:0]    r_edge_ptr;
    logic [CW-1:0]    r_rem_cnt;
    logic             r_next_valid;
    logic [NI-1:0]    r_next_node_idx;
    logic [CW-1:0]    r_next_node_counter;
    logic             r_done;
    logic             r_cfg_drop;

    logic             w_cfg_ok;
    logic             w_node_we;
    logic             w_edge_we;
    logic [EA+CW-1:0] w_node_rdata;
    logic [EA-1:0]    w_node_base;
    logic [CW-1:0]    w_node_deg;
    logic [NI-1:0]    w_edge_rdata;
    logic [EA-1:0]    w_edge_raddr;

    // Tables may only change while no node is being expanded
    assign w_cfg_ok    = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_node_we   = cfg_wr_en && w_cfg_ok && (cfg_sel == CFG_SEL_NODE);
    assign w_edge_we   = cfg_wr_en && w_cfg_ok && (cfg_sel == CFG_SEL_EDGE);
    assign w_node_base = w_node_rdata[EA+CW-1:CW];
    assign w_node_deg  = w_node_rdata[CW-1:0];

    graph_sp_ram #(
        .DATA_W (EA + CW),
        .ADDR_W (NI)
    ) u_node_tbl (
        .clk     (clk),
        .i_we    (w_node_we),
        .i_waddr (cfg_addr[NI-1:0]),
        .i_wdata (cfg_data),
        .i_raddr (node_idx),
        .o_rdata (w_node_rdata)
    );

    graph_sp_ram #(
        .DATA_W (NI),
        .ADDR_W (EA)
    ) u_edge_tbl (
        .clk     (clk),
        .i_we    (w_edge_we),
        .i_waddr (cfg_addr[EA-1:0]),
        .i_wdata (cfg_data[NI-1:0]),
        .i_raddr (w_edge_raddr),
        .o_rdata (w_edge_rdata)
    );

    // Edge read address: the first edge comes straight from the node entry, later ones from edge_ptr
    always_comb begin
        w_edge_raddr = r_edge_ptr;
        case (r_state)
            ST_LOOKUP: w_edge_raddr = w_node_base;
            default:   w_edge_raddr = r_edge_ptr;
        endcase
    end

    // Lookup/stream FSM; req restarts from any state and outranks advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state             <= ST_IDLE;
            r_edge_ptr          <= '0;
            r_rem_cnt           <= '0;
            r_next_valid        <= 1'b0;
            r_next_node_idx     <= '0;
            r_next_node_counter <= '0;
            r_done              <= 1'b0;
            r_cfg_drop          <= 1'b0;
        end else begin
            r_cfg_drop <= cfg_wr_en && !w_cfg_ok;
            if (req) begin
                r_state      <= ST_LOOKUP;
                r_next_valid <= 1'b0;
                r_done       <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        r_state <= r_state;
                    end
                    ST_LOOKUP: begin
                        r_rem_cnt <= w_node_deg;
                        if (w_node_deg == CW'(0)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_edge_ptr <= w_node_base + EA'(1);
                            r_state    <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        r_next_node_idx     <= w_edge_rdata;
                        r_next_node_counter <= r_rem_cnt;
                        r_next_valid        <= 1'b1;
                        r_state             <= ST_PRESENT;
                    end
                    ST_PRESENT: begin
                        if (advance) begin
                            r_next_valid <= 1'b0;
                            r_rem_cnt    <= r_rem_cnt - CW'(1);
                            if (r_rem_cnt == CW'(1)) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_edge_ptr <= r_edge_ptr + EA'(1);
                                r_state    <= ST_FETCH;
                            end
                        end
                    end
                    default: begin
                        r_state      <= ST_IDLE;
                        r_next_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cfg_drop          = r_cfg_drop;
    assign next_valid        = r_next_valid;
    assign next_node_idx     = r_next_node_idx;
    assign next_node_counter = r_next_node_counter;
    assign done              = r_done;

endmodule

// File: tb/tb_graph_edge_fetcher.sv
// Scoreboard bench for graph_edge_fetcher: stimulus pushes expected edges, a monitor pops and compares.
module tb_graph_edge_fetcher;
    import graph_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cfg_wr_en;
    logic        cfg_sel;
    logic [11:0] cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_drop;
    logic        req;
    logic [9:0]  node_idx;
    logic        advance;
    logic        next_valid;
    logic [9:0]  next_node_idx;
    logic [3:0]  next_node_counter;
    logic        done;

    typedef struct {
        int idx;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   vcycles[$];
    int   n_cmp      = 0;
    int   n_bad      = 0;
    int   cyc        = 0;
    int   done_cyc   = -1;
    int   drop_cnt   = 0;
    int   adv_budget = 0;
    int   t_req      = 0;
    logic prev_v     = 1'b0;
    logic prev_d     = 1'b0;

    graph_edge_fetcher dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_wr_en         (cfg_wr_en),
        .cfg_sel           (cfg_sel),
        .cfg_addr          (cfg_addr),
        .cfg_data          (cfg_data),
        .cfg_drop          (cfg_drop),
        .req               (req),
        .node_idx          (node_idx),
        .advance           (advance),
        .next_valid        (next_valid),
        .next_node_idx     (next_node_idx),
        .next_node_counter (next_node_counter),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic node_entry_t mk_node(input int base, input int deg);
        node_entry_t ne;
        ne.base   = base[11:0];
        ne.degree = deg[3:0];
        return ne;
    endfunction

    task automatic cfg_write(input logic sel, input int addr, input int data);
        @(negedge clk);
        cfg_wr_en = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = addr[11:0];
        cfg_data  = data[15:0];
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    task automatic do_req(input int n);
        @(negedge clk);
        req      = 1'b1;
        node_idx = n[9:0];
        t_req    = cyc;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: done timeout got 0 expected 1 within %0d cycles", name, limit);
        end
    endtask

    task automatic wait_valids(input string name, input int cnt, input int limit);
        int n = 0;
        while (vcycles.size() < cnt && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (vcycles.size() < cnt) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got %0d valids expected %0d", name, vcycles.size(), cnt);
        end
    endtask

    // Consumer model: takes each presented edge while budget remains
    initial begin
        advance = 1'b0;
        forever begin
            @(negedge clk);
            if (next_valid && adv_budget > 0) begin
                advance    = 1'b1;
                adv_budget = adv_budget - 1;
            end else begin
                advance = 1'b0;
            end
        end
    end

    // Monitor: compares every new edge presentation against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (next_valid && !prev_v) begin
                vcycles.push_back(cyc);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_edge: got idx %0d cnt %0d expected no edge",
                             next_node_idx, next_node_counter);
                end else begin
                    e = sb.pop_front();
                    check("edge_idx", int'(next_node_idx), e.idx);
                    check("edge_cnt", int'(next_node_counter), e.cnt);
                end
            end
            if (done && !prev_d) done_cyc = cyc;
            if (cfg_drop) drop_cnt++;
            prev_v = next_valid;
            prev_d = done;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int unstable;
        rst_n     = 1'b0;
        cfg_wr_en = 1'b0;
        cfg_sel   = 1'b0;
        cfg_addr  = 12'd0;
        cfg_data  = 16'd0;
        req       = 1'b0;
        node_idx  = 10'd0;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(next_valid), 0);
        check("rst_idx", int'(next_node_idx), 0);
        check("rst_cnt", int'(next_node_counter), 0);
        check("rst_done", int'(done), 0);
        check("rst_drop", int'(cfg_drop), 0);
        rst_n = 1'b1;

        cfg_write(CFG_SEL_NODE, 5, int'(mk_node(100, 3)));
        cfg_write(CFG_SEL_EDGE, 100, 7);
        cfg_write(CFG_SEL_EDGE, 101, 9);
        cfg_write(CFG_SEL_EDGE, 102, 11);
        cfg_write(CFG_SEL_NODE, 6, int'(mk_node(0, 0)));
        cfg_write(CFG_SEL_NODE, 1, int'(mk_node(4095, 2)));
        cfg_write(CFG_SEL_EDGE, 4095, 3);
        cfg_write(CFG_SEL_EDGE, 0, 4);
        @(negedge clk);
        check("load_no_drop", drop_cnt, 0);

        // Node 5 streamed with an eager consumer
        sb.push_back('{idx: 7, cnt: 3});
        sb.push_back('{idx: 9, cnt: 2});
        sb.push_back('{idx: 11, cnt: 1});
        vcycles.delete();
        done_cyc   = -1;
        adv_budget = 100;
        do_req(5);
        wait_done("n5_done", 40);
        wait_valids("n5_valids", 3, 2);
        if (vcycles.size() >= 3) begin
            check("n5_first_lat", vcycles[0] - t_req, 3);
            check("n5_gap1", vcycles[1] - vcycles[0], 2);
            check("n5_gap2", vcycles[2] - vcycles[1], 2);
            check("n5_done_lat", done_cyc - vcycles[2], 1);
        end
        check("n5_sb_empty", sb.size(), 0);

        // Degree-0 node
        vcycles.delete();
        done_cyc = -1;
        do_req(6);
        wait_done("n6_done", 20);
        repeat (4) @(negedge clk);
        check("n6_done_lat", done_cyc - t_req, 2);
        check("n6_no_valid", vcycles.size(), 0);

        // Edge pointer wraps from 4095 to 0
        sb.push_back('{idx: 3, cnt: 2});
        sb.push_back('{idx: 4, cnt: 1});
        vcycles.delete();
        do_req(1);
        wait_done("n1_done", 40);
        check("n1_sb_empty", sb.size(), 0);

        // Abort node 5 while its second edge is presented
        sb.push_back('{idx: 7, cnt: 3});
        sb.push_back('{idx: 9, cnt: 2});
        sb.push_back('{idx: 3, cnt: 2});
        sb.push_back('{idx: 4, cnt: 1});
        vcycles.delete();
        adv_budget = 1;
        do_req(5);
        wait_valids("abort_pre", 2, 30);
        req        = 1'b1;
        node_idx   = 10'd1;
        t_req      = cyc;
        adv_budget = 100;
        @(posedge clk);
        #1;
        check("abort_valid_drop", int'(next_valid), 0);
        @(negedge clk);
        req = 1'b0;
        wait_done("abort_done", 40);
        if (vcycles.size() >= 3) begin
            check("abort_new_lat", vcycles[2] - t_req, 3);
        end
        check("abort_sb_empty", sb.size(), 0);

        // Write and request in the same cycle: lookup sees the new entry
        sb.push_back('{idx: 9, cnt: 2});
        sb.push_back('{idx: 11, cnt: 1});
        @(negedge clk);
        cfg_wr_en = 1'b1;
        cfg_sel   = CFG_SEL_NODE;
        cfg_addr  = 12'd7;
        cfg_data  = mk_node(101, 2);
        req       = 1'b1;
        node_idx  = 10'd7;
        @(negedge clk);
        cfg_wr_en = 1'b0;
        req       = 1'b0;
        wait_done("wr_req_done", 40);
        check("wr_req_sb_empty", sb.size(), 0);

        // Write while presenting is dropped; outputs hold without advance
        sb.push_back('{idx: 7, cnt: 3});
        vcycles.delete();
        adv_budget = 0;
        do_req(5);
        wait_valids("drop_pre", 1, 30);
        cfg_write(CFG_SEL_NODE, 5, int'(mk_node(200, 1)));
        check("drop_pulse_hi", int'(cfg_drop), 1);
        @(negedge clk);
        check("drop_pulse_lo", int'(cfg_drop), 0);
        unstable = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!(next_valid && next_node_idx == 10'd7 && next_node_counter == 4'd3)) unstable++;
        end
        check("hold_stable", unstable, 0);

        // Asynchronous reset mid-stream
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(next_valid), 0);
        check("mid_rst_idx", int'(next_node_idx), 0);
        check("mid_rst_cnt", int'(next_node_counter), 0);
        check("mid_rst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Tables survive reset and the dropped write never landed
        sb.push_back('{idx: 7, cnt: 3});
        sb.push_back('{idx: 9, cnt: 2});
        sb.push_back('{idx: 11, cnt: 1});
        vcycles.delete();
        adv_budget = 100;
        do_req(5);
        wait_done("post_rst_done", 40);
        check("post_rst_sb_empty", sb.size(), 0);
        if (vcycles.size() >= 1) begin
            check("post_rst_lat", vcycles[0] - t_req, 3);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
